fle_ccff_loader: RTL and testbench

Configuration-chain loader for the `fle` logic tile. It accepts bitstream words over a valid/ready stream and serialises them onto `ccff_head`, one bit per enabled shift cycle. It asserts a shift enable for exactly `CHAIN_LEN` cycles, then reports completion. It sits between the bitstream source and the head of a tile's `ccff_head`→`ccff_tail` chain, in the `prog_clk` domain.

---
 rtl/fle_ccff_pkg.sv | 22 ++
 rtl/fle_ccff_rb_capture.sv | 76 +++++++
 rtl/fle_ccff_loader.sv | 180 ++++++++++++++++++
 tb/tb_fle_ccff_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fle_ccff_pkg.sv
// fle_ccff_pkg: shared types and constants for the fle configuration-chain loader.
//   ccff_state_t     - loader FSM states (IDLE, FETCH, SHIFT, DONE)
//   CCFF_*_DEFAULT   - default chain length and bitstream word width
//   words_per_load() - number of bitstream words needed to fill one chain
package fle_ccff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_t;

  localparam int CCFF_CHAIN_LEN_DEFAULT = 20;
  localparam int CCFF_WORD_W_DEFAULT    = 8;

  // Ceiling division: a partial final word still costs a whole fetch.
  function automatic int words_per_load(input int chain_len, input int word_w);
    return (chain_len + word_w - 32'sd1) / word_w;
  endfunction

endpackage

// File: rtl/fle_ccff_rb_capture.sv
// fle_ccff_rb_capture: collects the bits leaving the chain tail while a load
// shifts and presents them as bitstream-sized readback words.
//   clk, rst    - programming clock, synchronous active-high reset
//   sample_i    - a chain shift happens on the edge ending this cycle
//   tail_i      - chain tail bit, captured when sample_i is high
//   last_i      - this sample is the final one of the load (flush partial word)
//   flush_i     - discard any partially assembled word (load aborted)
//   rb_word_o   - assembled word, first sample in bit 0, zero-extended if partial
//   rb_valid_o  - one-cycle strobe accompanying a new rb_word_o
module fle_ccff_rb_capture #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_i,
  input  logic              tail_i,
  input  logic              last_i,
  input  logic              flush_i,
  output logic [WORD_W-1:0] rb_word_o,
  output logic              rb_valid_o
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] rb_word_q, rb_word_d;
  logic              rb_valid_q, rb_valid_d;
  logic [WORD_W-1:0] acc_next_s;

  // Next-state logic: place each sample at its bit position, emit on word end.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rb_word_d  = rb_word_q;
    rb_valid_d = 1'b0;
    // Positional insert keeps a short final word zero-extended for free.
    acc_next_s = acc_q | (WORD_W'(tail_i) << cnt_q);
    if (flush_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_i) begin
      if ((cnt_q == LAST_IDX) || last_i) begin
        rb_word_d  = acc_next_s;
        rb_valid_d = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
      end else begin
        acc_d = acc_next_s;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Readback registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      rb_word_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rb_word_q  <= rb_word_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_word_o  = rb_word_q;
  assign rb_valid_o = rb_valid_q;

endmodule

// File: rtl/fle_ccff_loader.sv
// fle_ccff_loader: streams bitstream words onto the ccff_head of an fle tile
// configuration chain, one bit per shift_en cycle, for exactly CHAIN_LEN cycles.
// Optional readback of the displaced chain contents is built when the macro
// FLE_CCFF_READBACK_EN is defined; otherwise rb_word/rb_valid are tied to 0.
//   prog_clk, pReset     - programming clock, synchronous active-high reset
//   start, abort         - begin a load (IDLE only) / cancel a load (FETCH, SHIFT)
//   cfg_data/valid/ready - bitstream word stream, bit 0 shifted first
//   ccff_head, shift_en  - registered serial data and shift enable to the chain
//   ccff_tail            - chain tail, sampled only for readback
//   busy, done, err      - loading / load-complete pulse / sticky abort flag
//   rb_word, rb_valid    - readback word and its strobe
module fle_ccff_loader
  import fle_ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEFAULT,
  parameter int WORD_W    = CCFF_WORD_W_DEFAULT
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid
);

  localparam int BIT_CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WORD_CNT_W = $clog2(WORD_W + 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(CHAIN_LEN - 1);
  localparam logic [WORD_CNT_W-1:0] LAST_WBIT = WORD_CNT_W'(WORD_W - 1);

  ccff_state_t           state_q, state_d;
  logic [WORD_W-1:0]     sreg_q, sreg_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic                  ccff_head_q, ccff_head_d;
  logic                  shift_en_q, shift_en_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // FSM and datapath next state. The output registers are loaded with the bit
  // that belongs to the *next* cycle, so sreg holds only the bits still to be
  // sent and the first bit appears on ccff_head in the first SHIFT cycle.
  // During SHIFT, bit_cnt/word_cnt index the bit currently on ccff_head.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    ccff_head_d = ccff_head_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          err_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (cfg_valid) begin
          state_d     = SHIFT;
          ccff_head_d = cfg_data[0];
          sreg_d      = cfg_data >> 1'b1;
          word_cnt_d  = '0;
        end else begin
          state_d = FETCH;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
          word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
          // Chain end takes priority; it also discards unused upper word bits.
          if (bit_cnt_q == LAST_BIT) begin
            state_d = DONE;
          end else if (word_cnt_q == LAST_WBIT) begin
            state_d = FETCH;
          end else begin
            ccff_head_d = sreg_q[0];
            sreg_d      = sreg_q >> 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered decodes of the next state line up with state_q next cycle.
    shift_en_d  = (state_d == SHIFT);
    cfg_ready_d = (state_d == FETCH);
    busy_d      = (state_d == FETCH) || (state_d == SHIFT);
    done_d      = (state_d == DONE);
  end

  // All loader state and registered outputs, synchronous reset.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      ccff_head_q <= 1'b0;
      shift_en_q  <= 1'b0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      ccff_head_q <= ccff_head_d;
      shift_en_q  <= shift_en_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign ccff_head = ccff_head_q;
  assign shift_en  = shift_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef FLE_CCFF_READBACK_EN
  logic rb_last_s;
  logic rb_flush_s;

  // bit_cnt_q indexes the bit being shifted, so this marks the load's last sample.
  assign rb_last_s  = shift_en_q && (bit_cnt_q == LAST_BIT);
  assign rb_flush_s = abort && busy_q;

  fle_ccff_rb_capture #(
    .WORD_W (WORD_W)
  ) u_rb_capture (
    .clk        (prog_clk),
    .rst        (pReset),
    .sample_i   (shift_en_q),
    .tail_i     (ccff_tail),
    .last_i     (rb_last_s),
    .flush_i    (rb_flush_s),
    .rb_word_o  (rb_word),
    .rb_valid_o (rb_valid)
  );
`else
  logic tail_unused_s;

  assign tail_unused_s = ccff_tail;
  assign rb_word       = '0;
  assign rb_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_fle_ccff_loader.sv
// tb_fle_ccff_loader: directed self-checking bench for fle_ccff_loader
// (CHAIN_LEN=20, WORD_W=8) with a behavioural 20-stage chain on ccff_head/ccff_tail.
module tb_fle_ccff_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam logic [19:0] EXP_BITS = 20'hF3CA5; // serial order, bit i = i-th bit sent

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic          start;
  logic          abort;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          ccff_head;
  logic          shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic          err;
  logic [WW-1:0] rb_word;
  logic          rb_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] words [0:2];

  // Per-cycle history of one load, index n = cycle k+n after start sampled at edge k.
  logic se_h [0:63];
  logic hd_h [0:63];
  logic dn_h [0:63];
  logic bz_h [0:63];
  logic rd_h [0:63];
  logic er_h [0:63];
  logic rv_h [0:63];
  logic [63:0] bits_v;
  int          n_bits;
  logic [7:0]  rb_q [0:7];
  int          rb_n;

  logic [CL-1:0] chain = '0;
  logic          chain_load = 1'b0;

  fle_ccff_loader #(
    .CHAIN_LEN (CL),
    .WORD_W    (WW)
  ) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start),
    .abort     (abort),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .ccff_head (ccff_head),
    .shift_en  (shift_en),
    .ccff_tail (ccff_tail),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rb_word   (rb_word),
    .rb_valid  (rb_valid)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural configuration chain: head enters stage 0, tail is the last stage.
  always @(posedge prog_clk) begin
    if (chain_load) chain <= '1;
    else if (shift_en === 1'b1) chain <= {chain[CL-2:0], ccff_head};
  end
  assign ccff_tail = chain[CL-1];

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // Drives one load with a simple source model and records the outputs per cycle.
  task automatic run_load(input int stall_word, input int stall_cycles, input int abort_n,
                          input int restart_n, input int reset_n, input int ncyc);
    int w;
    int stall_left;
    w = 0;
    stall_left = stall_cycles;
    n_bits = 0;
    bits_v = '0;
    rb_n = 0;
    for (int i = 0; i < 64; i++) begin
      se_h[i] = 1'b0; hd_h[i] = 1'b0; dn_h[i] = 1'b0; bz_h[i] = 1'b0;
      rd_h[i] = 1'b0; er_h[i] = 1'b0; rv_h[i] = 1'b0;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      se_h[n] = shift_en; hd_h[n] = ccff_head; dn_h[n] = done; bz_h[n] = busy;
      rd_h[n] = cfg_ready; er_h[n] = err; rv_h[n] = rb_valid;
      if (shift_en === 1'b1 && n_bits < 64) begin
        bits_v[n_bits] = ccff_head;
        n_bits++;
      end
      if (rb_valid === 1'b1 && rb_n < 8) begin
        rb_q[rb_n] = rb_word;
        rb_n++;
      end
      abort  = (n == abort_n);
      start  = (n == restart_n);
      pReset = (n == reset_n);
      if (w < 3) begin
        cfg_data  = words[w];
        cfg_valid = 1'b1;
      end else begin
        cfg_data  = '0;
        cfg_valid = 1'b0;
      end
      if (cfg_ready === 1'b1 && w == stall_word && stall_left > 0) begin
        cfg_valid = 1'b0;
        stall_left--;
      end
      if (cfg_valid && cfg_ready === 1'b1 && !abort && !pReset) w++;
      step();
    end
    abort = 1'b0; start = 1'b0; pReset = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
  endtask

  task automatic test_reset();
    pReset = 1'b1;
    step(); step();
    n_tests++;
    if ({shift_en, ccff_head, cfg_ready, busy, done, err, rb_valid} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {shift_en, ccff_head, cfg_ready, busy, done, err, rb_valid});
    end
    n_tests++;
    if (rb_word !== 8'h00) begin
      n_fail++; $display("FAIL reset_rb_word: got %h expected 00", rb_word);
    end
    pReset = 1'b0;
    step(); step();
    n_tests++;
    if ({shift_en, cfg_ready, busy, done} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 0000", {shift_en, cfg_ready, busy, done});
    end
  endtask

  task automatic test_full_load();
    int se_bad;
    int dn_cnt;
    int rd_cnt;
    logic [CL-1:0] exp_chain;
    run_load(-1, 0, -1, -1, -1, 30);
    se_bad = 0; dn_cnt = 0; rd_cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      if (se_h[n] !== ((n >= 2 && n <= 9) || (n >= 11 && n <= 18) || (n >= 20 && n <= 23))) se_bad++;
      if (dn_h[n] === 1'b1) dn_cnt++;
      if (rd_h[n] === 1'b1) rd_cnt++;
    end
    n_tests++;
    if (rd_h[1] !== 1'b1) begin n_fail++; $display("FAIL full_ready_k1: got %b expected 1", rd_h[1]); end
    n_tests++;
    if (rd_cnt != 3) begin n_fail++; $display("FAIL full_fetch_cycles: got %0d expected 3", rd_cnt); end
    n_tests++;
    if (n_bits != 20) begin n_fail++; $display("FAIL full_shift_count: got %0d expected 20", n_bits); end
    n_tests++;
    if (bits_v[19:0] !== EXP_BITS) begin
      n_fail++; $display("FAIL full_bits: got %h expected %h", bits_v[19:0], EXP_BITS);
    end
    n_tests++;
    if (se_bad != 0) begin n_fail++; $display("FAIL full_shift_window: got %0d bad cycles expected 0", se_bad); end
    n_tests++;
    if (dn_h[24] !== 1'b1 || dn_cnt != 1) begin
      n_fail++; $display("FAIL full_done_k24: got done@24=%b pulses=%0d expected 1 and 1", dn_h[24], dn_cnt);
    end
    n_tests++;
    if (bz_h[23] !== 1'b1 || bz_h[24] !== 1'b0 || bz_h[25] !== 1'b0) begin
      n_fail++; $display("FAIL full_busy: got %b%b%b expected 100", bz_h[23], bz_h[24], bz_h[25]);
    end
    for (int i = 0; i < CL; i++) exp_chain[CL-1-i] = EXP_BITS[i];
    n_tests++;
    if (chain !== exp_chain) begin n_fail++; $display("FAIL full_chain: got %h expected %h", chain, exp_chain); end
  endtask

  task automatic test_stall();
    int frz_bad;
    run_load(1, 5, -1, -1, -1, 35);
    frz_bad = 0;
    for (int n = 10; n <= 15; n++) begin
      if (se_h[n] !== 1'b0 || hd_h[n] !== 1'b1) frz_bad++;
    end
    n_tests++;
    if (frz_bad != 0) begin n_fail++; $display("FAIL stall_frozen: got %0d bad cycles expected 0", frz_bad); end
    n_tests++;
    if (n_bits != 20 || bits_v[19:0] !== EXP_BITS) begin
      n_fail++; $display("FAIL stall_bits: got %0d bits %h expected 20 bits %h", n_bits, bits_v[19:0], EXP_BITS);
    end
    n_tests++;
    if (dn_h[29] !== 1'b1 || dn_h[24] !== 1'b0) begin
      n_fail++; $display("FAIL stall_done_k29: got done@29=%b done@24=%b expected 1 0", dn_h[29], dn_h[24]);
    end
  endtask

  task automatic test_abort();
    int dn_cnt;
    run_load(-1, 0, 13, -1, -1, 30);
    dn_cnt = 0;
    for (int n = 1; n <= 30; n++) if (dn_h[n] === 1'b1) dn_cnt++;
    n_tests++;
    if (se_h[13] !== 1'b1 || se_h[14] !== 1'b0) begin
      n_fail++; $display("FAIL abort_shift_en: got %b%b expected 10", se_h[13], se_h[14]);
    end
    n_tests++;
    if (er_h[13] !== 1'b0 || er_h[14] !== 1'b1) begin
      n_fail++; $display("FAIL abort_err: got %b%b expected 01", er_h[13], er_h[14]);
    end
    n_tests++;
    if (n_bits != 11 || dn_cnt != 0) begin
      n_fail++; $display("FAIL abort_count: got bits=%0d done=%0d expected 11 0", n_bits, dn_cnt);
    end
    n_tests++;
    if (bz_h[14] !== 1'b0 || rd_h[14] !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b ready=%b expected 0 0", bz_h[14], rd_h[14]);
    end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL abort_sticky: got %b expected 1", err); end
    run_load(-1, 0, -1, -1, -1, 30);
    n_tests++;
    if (er_h[1] !== 1'b0) begin n_fail++; $display("FAIL restart_err_clear: got %b expected 0", er_h[1]); end
    n_tests++;
    if (n_bits != 20 || bits_v[19:0] !== EXP_BITS || dn_h[24] !== 1'b1) begin
      n_fail++; $display("FAIL restart_load: got %0d bits %h done=%b expected 20 bits %h done=1",
                         n_bits, bits_v[19:0], dn_h[24], EXP_BITS);
    end
  endtask

  task automatic test_start_in_shift();
    run_load(-1, 0, -1, 5, -1, 30);
    n_tests++;
    if (n_bits != 20 || bits_v[19:0] !== EXP_BITS) begin
      n_fail++; $display("FAIL busy_start_bits: got %0d bits %h expected 20 bits %h", n_bits, bits_v[19:0], EXP_BITS);
    end
    n_tests++;
    if (dn_h[24] !== 1'b1 || bz_h[6] !== 1'b1) begin
      n_fail++; $display("FAIL busy_start_done: got done@24=%b busy@6=%b expected 1 1", dn_h[24], bz_h[6]);
    end
  endtask

  task automatic test_reset_mid();
    run_load(-1, 0, -1, -1, 7, 12);
    n_tests++;
    if (se_h[7] !== 1'b1 || hd_h[7] !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got se=%b head=%b expected 1 1", se_h[7], hd_h[7]);
    end
    n_tests++;
    if ({se_h[8], hd_h[8], dn_h[8], bz_h[8], rd_h[8], er_h[8], rv_h[8]} !== 7'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %b expected 0000000",
                         {se_h[8], hd_h[8], dn_h[8], bz_h[8], rd_h[8], er_h[8], rv_h[8]});
    end
    run_load(-1, 0, -1, -1, -1, 30);
    n_tests++;
    if (n_bits != 20 || bits_v[19:0] !== EXP_BITS || dn_h[24] !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_reload: got %0d bits %h done=%b expected 20 bits %h done=1",
                         n_bits, bits_v[19:0], dn_h[24], EXP_BITS);
    end
  endtask

  task automatic test_readback();
    chain_load = 1'b1;
    step();
    chain_load = 1'b0;
    step();
    run_load(-1, 0, -1, -1, -1, 30);
`ifdef FLE_CCFF_READBACK_EN
    n_tests++;
    if (rb_n != 3) begin n_fail++; $display("FAIL rb_strobes: got %0d expected 3", rb_n); end
    n_tests++;
    if (rb_q[0] !== 8'hFF || rb_q[1] !== 8'hFF || rb_q[2] !== 8'h0F) begin
      n_fail++; $display("FAIL rb_words: got %h %h %h expected ff ff 0f", rb_q[0], rb_q[1], rb_q[2]);
    end
    n_tests++;
    if (rv_h[10] !== 1'b1 || rv_h[19] !== 1'b1 || rv_h[24] !== 1'b1) begin
      n_fail++; $display("FAIL rb_timing: got %b%b%b expected 111", rv_h[10], rv_h[19], rv_h[24]);
    end
`else
    n_tests++;
    if (rb_n != 0 || rb_word !== 8'h00) begin
      n_fail++; $display("FAIL rb_disabled: got strobes=%0d word=%h expected 0 00", rb_n, rb_word);
    end
`endif
  endtask

  initial begin
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'h0F;
    pReset = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    #1;
    test_reset();
    test_full_load();
    step();
    test_stall();
    step();
    test_abort();
    step();
    test_start_in_shift();
    step();
    test_reset_mid();
    step();
    test_readback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
